seq_divider: RTL
================

Name: seq_divider

Overview:
- Iterative restoring divider; the inverse operation of the team's 3x3 array multiplier.
- Takes a 6-bit dividend, the width of a multiplier product, and a 3-bit divisor, the width of a multiplier operand.
- Returns quotient and remainder, one quotient bit per clock, MSB first.
- Used in the ALU datapath and for round-trip checking of multiplier results (P / A = B).

Parameters:
- WN, 6, dividend and quotient width.
- WD, 3, divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on a clk edge while busy=0
- N  input  WN  dividend; captured on the accepted start edge
- D  input  WD  divisor; captured on the accepted start edge
- Q  output  WN  quotient; registered
- R  output  WD  remainder; registered
- busy  output  1  high while computing
- done  output  1  one-cycle pulse; Q/R/dz valid
- dz  output  1  divide-by-zero flag for the current result

Behaviour:
- Reset: one clock and one reset. Reset is asynchronous and active-low (rst_n). While rst_n=0, every register clears immediately, independent of clk.
  - Outputs: Q=0, R=0, busy=0, done=0, dz=0.
  - State=IDLE, counter=0.
- States:
  - IDLE: waiting for start.
  - CALC: iterating.
  - FIN: done pulse cycle.
- IDLE/FIN + start=1, D!=0 -> CALC.
  - On that edge: latch N into the dividend shift register, latch D, clear the partial remainder (WD+1 bits), counter=0, busy=1.
- IDLE/FIN + start=1, D==0 -> FIN.
  - On that edge: Q=all ones, R=0, dz=1, done=1. Latency is 1 edge.
- CALC, each edge:
  - rem' = {rem[WD-1:0], dividend MSB}.
  - If rem' >= {0,D}: rem' = rem' - D and quotient bit = 1; else quotient bit = 0.
  - Shift the quotient bit into the quotient LSB; shift the dividend left; counter+1.
- CALC completion: on the WN-th CALC edge, state=FIN and Q/R are written from the final quotient and remainder. dz=0, done=1, busy=0.
- Latency: start sampled at edge k -> done=1 in the cycle after edge k+WN.
- FIN lasts one cycle; done=0 on the next edge.
  - start=1 in FIN begins a new operation (back-to-back, no idle gap).
  - start=0 in FIN -> IDLE.
- start while busy=1 is ignored. N/D changes during CALC have no effect; operands are latched.
- Q, R and dz hold their last values until the next completion. They never show intermediate values.
- Arithmetic: unsigned. Q = floor(N/D), R = N mod D, R < D. The remainder fits WD bits; the WD+1-bit internal register handles the pre-subtract overflow.
- rst_n low mid-CALC aborts immediately. No done pulse follows release; the block returns to IDLE with cleared outputs.
- Counter: wide enough for WN (3 bits at default); saturates at WN and does not wrap.

Test Plan:
- Reset, then start with N=42, D=5 -> busy for 6 cycles; done pulse in cycle 7 after the start edge; Q=8, R=2, dz=0.
- Multiplier round-trip: N=30 (5*6), D=5 -> Q=6, R=0. N=49 (7*7), D=7 -> Q=7, R=0. N=63, D=1 -> Q=63, R=0.
- N=20, D=0 -> done one cycle after the start edge, dz=1, Q=63, R=0, busy never high. The next normal operation clears dz.
- Start held high during CALC with new operands N=9, D=2 -> ignored; the original result N=42, D=5 -> Q=8, R=2 is delivered. With start still high in FIN, N=9, D=2 begins immediately and yields Q=4, R=1.
- rst_n pulled low at CALC cycle 3 asynchronously, between edges -> outputs clear at once; no done after release. A fresh N=0, D=3 then gives Q=0, R=0.
- Exhaustive: all N in 0..63 and D in 1..7 -> Q*D+R==N and R<D for every pair.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// State | meaning: IDLE = waiting for start; CALC = iterating; FIN = done pulse cycle.
module seq_divider #(
  parameter int WN = 6,
  parameter int WD = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WN-1:0] N,
  input  logic [WD-1:0] D,
  output logic [WN-1:0] Q,
  output logic [WD-1:0] R,
  output logic          busy,
  output logic          done,
  output logic          dz
);

  localparam int CW = $clog2(WN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [WN-1:0] r_dvd;
  logic [WD-1:0] r_div;
  logic [WD:0]   r_rem;
  logic [WN-1:0] r_quo;
  logic [WN-1:0] r_q;
  logic [WD-1:0] r_r;
  logic          r_dz;

  logic          w_accept;
  logic          w_last;
  logic [WD:0]   w_rem_sh;
  logic          w_ge;
  logic [WD:0]   w_rem_nx;
  logic [WN-1:0] w_quo_nx;

  assign w_accept = (r_state != S_CALC) && start;
  assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(WN - 1));

  // The extra remainder bit holds the shifted-in value before the trial subtract.
  assign w_rem_sh = {r_rem[WD-1:0], r_dvd[WN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;
  assign w_quo_nx = {r_quo[WN-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (start) w_state_nx = (D == '0) ? S_FIN : S_CALC;
        else       w_state_nx = S_IDLE;
      end
      S_CALC: begin
        if (w_last) w_state_nx = S_FIN;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dvd <= '0;
      r_div <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dz  <= 1'b0;
    end else if (w_accept) begin
      if (D == '0) begin
        r_q  <= '1;
        r_r  <= '0;
        r_dz <= 1'b1;
      end else begin
        r_dvd <= N;
        r_div <= D;
        r_rem <= '0;
        r_quo <= '0;
        r_cnt <= '0;
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_dvd <= {r_dvd[WN-2:0], 1'b0};
      if (r_cnt != CW'(WN)) r_cnt <= r_cnt + 1'b1;
      // Results are published only on the final iteration, never mid-way.
      if (w_last) begin
        r_q  <= w_quo_nx;
        r_r  <= w_rem_nx[WD-1:0];
        r_dz <= 1'b0;
      end
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign dz   = r_dz;
  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_FIN);

endmodule
